// File: rtl/snn_cu_seq.sv
// snn_cu_seq: sequential leaky integrate-and-fire compute unit.
// NUM_PES lanes step through a T_STEPS spike train per job. Each step leaks,
// integrates a signed weight, saturates and fires against a shared threshold.
// Results leave on a valid/ready stream, one registered step per handshake.
module snn_cu_seq #(
  parameter int NUM_PES   = 4,
  parameter int T_STEPS   = 8,
  parameter int W_WIDTH   = 8,
  parameter int V_WIDTH   = 12,
  parameter int CNT_WIDTH = $clog2(T_STEPS + 1)
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start,
  input  logic [NUM_PES*T_STEPS-1:0]     input_spikes,
  input  logic [NUM_PES*W_WIDTH-1:0]     weights,
  input  logic [V_WIDTH-1:0]             vth,
  input  logic                           mode,
  input  logic [3:0]                     leak_shift,
  input  logic [3:0]                     refrac_steps,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(T_STEPS)-1:0]     out_step,
  output logic [NUM_PES-1:0]             output_spikes,
  output logic [NUM_PES*CNT_WIDTH-1:0]   spike_count,
  output logic                           done
);

  localparam int STEP_W = $clog2(T_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);
  localparam logic signed [V_WIDTH-1:0] VN_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] VN_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      state_q;
  logic                        busy_q, out_valid_q, done_q;
  logic [STEP_W-1:0]           step_q, out_step_q;
  logic [NUM_PES-1:0]          out_spk_q;

  // Job configuration captured on start.
  logic [T_STEPS-1:0]          spikes_q [NUM_PES];
  logic signed [W_WIDTH-1:0]   w_q      [NUM_PES];
  logic [V_WIDTH-1:0]          vth_q;
  logic                        mode_q;
  logic [3:0]                  leak_q;
  logic [3:0]                  refrac_q;

  // Per-lane neuron state.
  logic signed [V_WIDTH-1:0]   v_q    [NUM_PES];
  logic [3:0]                  refr_q [NUM_PES];
  logic [CNT_WIDTH-1:0]        cnt_q  [NUM_PES];

  // Per-lane step datapath.
  logic signed [V_WIDTH-1:0]   leak_w [NUM_PES];
  logic signed [V_WIDTH-1:0]   vl_w   [NUM_PES];
  logic signed [V_WIDTH:0]     x_w    [NUM_PES];
  logic signed [V_WIDTH:0]     sum_w  [NUM_PES];
  logic signed [V_WIDTH-1:0]   vn_w   [NUM_PES];
  logic signed [V_WIDTH:0]     diff_w [NUM_PES];
  logic signed [V_WIDTH-1:0]   v_d    [NUM_PES];
  logic [3:0]                  refr_d [NUM_PES];
  logic [CNT_WIDTH-1:0]        cnt_d  [NUM_PES];
  logic [NUM_PES-1:0]          fire_d;
  logic signed [V_WIDTH:0]     vth_ext;

  // Threshold is unsigned; one extra zero bit lets it compare as signed.
  assign vth_ext = {1'b0, vth_q};

  // Compute the next membrane, refractory and count values for step_q.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    fire_d = '0;
    for (int i = 0; i < NUM_PES; i++) begin
      leak_w[i] = '0;
      if (leak_q != 4'd0) leak_w[i] = v_q[i] >>> leak_q;
      vl_w[i] = v_q[i] - leak_w[i];

      x_w[i] = '0;
      if (refr_q[i] == 4'd0 && spikes_q[i][step_q]) x_w[i] = w_q[i];

      sum_w[i] = (V_WIDTH+1)'(vl_w[i]) + x_w[i];
      if (sum_w[i] > (V_WIDTH+1)'(VN_MAX))      vn_w[i] = VN_MAX;
      else if (sum_w[i] < (V_WIDTH+1)'(VN_MIN)) vn_w[i] = VN_MIN;
      else                                       vn_w[i] = sum_w[i][V_WIDTH-1:0];

      fire_d[i] = ((V_WIDTH+1)'(vn_w[i]) >= vth_ext);
      diff_w[i] = (V_WIDTH+1)'(vn_w[i]) - vth_ext;

      v_d[i]    = vn_w[i];
      refr_d[i] = (refr_q[i] != 4'd0) ? refr_q[i] - 4'd1 : refr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (fire_d[i]) begin
        v_d[i]    = mode_q ? diff_w[i][V_WIDTH-1:0] : '0;
        refr_d[i] = refrac_q;
        cnt_d[i]  = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Job FSM with registered stream outputs and lane state updates.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      step_q      <= '0;
      out_step_q  <= '0;
      out_spk_q   <= '0;
      vth_q       <= '0;
      mode_q      <= 1'b0;
      leak_q      <= '0;
      refrac_q    <= '0;
      // NOTE: lane arrays are flops, not RAM, so resetting them is legal and cheap.
      for (int i = 0; i < NUM_PES; i++) begin
        spikes_q[i] <= '0;
        w_q[i]      <= '0;
        v_q[i]      <= '0;
        refr_q[i]   <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            step_q     <= '0;
            out_step_q <= '0;
            out_spk_q  <= '0;
            vth_q      <= vth;
            mode_q     <= mode;
            leak_q     <= leak_shift;
            refrac_q   <= refrac_steps;
            for (int i = 0; i < NUM_PES; i++) begin
              spikes_q[i] <= input_spikes[i*T_STEPS +: T_STEPS];
              w_q[i]      <= weights[i*W_WIDTH +: W_WIDTH];
              v_q[i]      <= '0;
              refr_q[i]   <= '0;
              cnt_q[i]    <= '0;
            end
          end
        end
        S_RUN: begin
          if (!out_valid_q || out_ready) begin
            if (out_valid_q && out_step_q == LAST_STEP) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              out_valid_q <= 1'b1;
              out_step_q  <= step_q;
              out_spk_q   <= fire_d;
              step_q      <= step_q + STEP_W'(1);
              for (int i = 0; i < NUM_PES; i++) begin
                v_q[i]    <= v_d[i];
                refr_q[i] <= refr_d[i];
                cnt_q[i]  <= cnt_d[i];
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign out_valid     = out_valid_q;
  assign out_step      = out_step_q;
  assign output_spikes = out_spk_q;
  assign done          = done_q;

  for (genvar g = 0; g < NUM_PES; g++) begin : g_cnt
    assign spike_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_snn_cu_seq.sv
// tb_snn_cu_seq: randomized self-checking bench for snn_cu_seq.
// A per-lane integer model predicts fire flags and running counts per step.
module tb_snn_cu_seq;

  localparam int NP = 4;
  localparam int TS = 32;
  localparam int WW = 8;
  localparam int VW = 12;
  localparam int CW = $clog2(TS + 1);
  localparam int SW = $clog2(TS);

  logic                clk = 1'b0;
  logic                nrst;
  logic                start;
  logic [NP*TS-1:0]    input_spikes;
  logic [NP*WW-1:0]    weights;
  logic [VW-1:0]       vth;
  logic                mode;
  logic [3:0]          leak_shift;
  logic [3:0]          refrac_steps;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [SW-1:0]       out_step;
  logic [NP-1:0]       output_spikes;
  logic [NP*CW-1:0]    spike_count;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;

  // Job configuration under test.
  logic [NP*TS-1:0]    cfg_spk;
  logic [NP*WW-1:0]    cfg_w;
  logic [VW-1:0]       cfg_vth;
  logic                cfg_mode;
  logic [3:0]          cfg_leak;
  logic [3:0]          cfg_refr;

  // Expected fire flags and running counts after each step.
  logic [NP-1:0]       exp_fire [TS];
  logic [NP*CW-1:0]    exp_cnt  [TS];

  snn_cu_seq #(
    .NUM_PES(NP), .T_STEPS(TS), .W_WIDTH(WW), .V_WIDTH(VW)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .input_spikes(input_spikes),
    .weights(weights), .vth(vth), .mode(mode), .leak_shift(leak_shift),
    .refrac_steps(refrac_steps), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_step(out_step), .output_spikes(output_spikes),
    .spike_count(spike_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Integer LIF model straight from the lane rules.
  task automatic build_model();
    int v, r, c, w, vl, x, vn, th;
    bit f;
    th = int'(cfg_vth);
    for (int t = 0; t < TS; t++) begin
      exp_fire[t] = '0;
      exp_cnt[t]  = '0;
    end
    for (int i = 0; i < NP; i++) begin
      v = 0; r = 0; c = 0;
      w = int'($signed(cfg_w[i*WW +: WW]));
      for (int t = 0; t < TS; t++) begin
        vl = (cfg_leak != 4'd0) ? v - (v >>> cfg_leak) : v;
        x = 0;
        if (r > 0) r = r - 1;
        else if (cfg_spk[i*TS + t]) x = w;
        vn = vl + x;
        if (vn > 2047)  vn = 2047;
        if (vn < -2048) vn = -2048;
        f = (vn >= th);
        if (f) begin
          v = cfg_mode ? vn - th : 0;
          r = int'(cfg_refr);
          c = c + 1;
        end else begin
          v = vn;
        end
        exp_fire[t][i] = f;
        exp_cnt[t][i*CW +: CW] = CW'(c);
      end
    end
  endtask

  task automatic scramble_inputs();
    input_spikes = {$urandom(), $urandom(), $urandom(), $urandom()};
    weights      = 32'($urandom());
    vth          = VW'($urandom());
    mode         = 1'($urandom_range(0, 1));
    leak_shift   = 4'($urandom_range(0, 15));
    refrac_steps = 4'($urandom_range(0, 15));
  endtask

  task automatic set_directed(input logic [WW-1:0] w, input int th, input bit m,
                              input int lk, input int rf);
    cfg_spk  = '1;
    cfg_w    = {NP{w}};
    cfg_vth  = VW'(th);
    cfg_mode = m;
    cfg_leak = 4'(lk);
    cfg_refr = 4'(rf);
  endtask

  task automatic set_random();
    cfg_spk  = {$urandom(), $urandom(), $urandom(), $urandom()};
    cfg_w    = 32'($urandom());
    cfg_vth  = VW'($urandom_range(0, 80));
    cfg_mode = 1'($urandom_range(0, 1));
    cfg_leak = 4'($urandom_range(0, 4));
    cfg_refr = 4'($urandom_range(0, 3));
  endtask

  // Runs one job from IDLE; called and returns on a negedge.
  // rst_step >= 0 aborts with a reset when that step is on the output.
  // plan_cnt >= 0 is the lane-0 final count worked out by hand.
  task automatic run_job(input bit rand_ready, input int rst_step, input int plan_cnt);
    int idx, budget;
    bit rdy;
    build_model();
    check("idle_busy", 64'(busy), 64'(0));
    input_spikes = cfg_spk; weights = cfg_w; vth = cfg_vth; mode = cfg_mode;
    leak_shift = cfg_leak; refrac_steps = cfg_refr;
    start = 1'b1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    check("run_busy", 64'(busy), 64'(1));
    check("valid_c1", 64'(out_valid), 64'(0));
    scramble_inputs();
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("valid_c2", 64'(out_valid), 64'(1));
    idx = 0; budget = 0;
    while (idx < TS && budget < 20*TS) begin
      check("valid", 64'(out_valid), 64'(1));
      check("step", 64'(out_step), 64'(idx));
      check("spikes", 64'(output_spikes), 64'(exp_fire[idx]));
      check("count", 64'(spike_count), 64'(exp_cnt[idx]));
      check("done_low", 64'(done), 64'(0));
      if (idx == rst_step) begin
        nrst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_spikes", 64'(output_spikes), 64'(0));
        check("rst_step", 64'(out_step), 64'(0));
        check("rst_count", 64'(spike_count), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        nrst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("post_rst_done", 64'(done), 64'(0));
          check("post_rst_busy", 64'(busy), 64'(0));
        end
        return;
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      scramble_inputs();
      start = (idx == TS-1) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rdy) idx++;
      budget++;
    end
    if (idx < TS) begin
      check("cycle_budget", 64'(0), 64'(1));
      return;
    end
    start = 1'b0;
    check("end_valid", 64'(out_valid), 64'(0));
    check("done_pulse", 64'(done), 64'(1));
    check("done_busy", 64'(busy), 64'(1));
    check("final_count", 64'(spike_count), 64'(exp_cnt[TS-1]));
    @(negedge clk);
    check("done_once", 64'(done), 64'(0));
    check("idle_again", 64'(busy), 64'(0));
    @(negedge clk);
    check("no_restart", 64'(busy), 64'(0));
    check("count_hold", 64'(spike_count), 64'(exp_cnt[TS-1]));
    if (plan_cnt >= 0)
      check("plan_count", 64'(spike_count[CW-1:0]), 64'(plan_cnt));
  endtask

  initial begin
    nrst = 1'b1; start = 1'b0; out_ready = 1'b0;
    input_spikes = '0; weights = '0; vth = '0; mode = 1'b0;
    leak_shift = '0; refrac_steps = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_valid", 64'(out_valid), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_spikes", 64'(output_spikes), 64'(0));
    check("reset_step", 64'(out_step), 64'(0));
    check("reset_count", 64'(spike_count), 64'(0));
    nrst = 1'b0;
    @(negedge clk);

    set_directed(8'h04, 10, 1'b0, 0, 0);   run_job(1'b0, -1, 10);
    set_directed(8'h04, 10, 1'b1, 0, 0);   run_job(1'b0, -1, 12);
    set_directed(8'h04, 10, 1'b0, 0, 1);   run_job(1'b0, -1, 8);
    set_directed(8'h08, 100, 1'b0, 1, 0);  run_job(1'b0, -1, 0);
    set_directed(8'h7F, 2047, 1'b0, 0, 0); run_job(1'b0, -1, 1);
    set_directed(8'h80, 2047, 1'b0, 0, 0); run_job(1'b0, -1, 0);
    set_directed(8'h80, 0, 1'b1, 2, 2);    run_job(1'b1, -1, -1);

    for (int j = 0; j < 8; j++) begin
      set_random();
      run_job(1'b1, -1, -1);
    end

    set_random();
    run_job(1'b1, 3, -1);
    set_random();
    run_job(1'b1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
